// File: rtl/core_pkg.sv
// core_pkg: shared phase encoding and constants for the instruction-cycle sequencer
package core_pkg;
  typedef enum logic [4:0] {
    IDLE = 5'b00001,
    Q1   = 5'b00010,
    Q2   = 5'b00100,
    Q3   = 5'b01000,
    Q4   = 5'b10000
  } phase_t;
  localparam logic [1:0] PHASE_Q1 = 2'd0;
  localparam logic [1:0] PHASE_Q2 = 2'd1;
  localparam logic [1:0] PHASE_Q3 = 2'd2;
  localparam logic [1:0] PHASE_Q4 = 2'd3;
  localparam int CNT_W_DEFAULT = 16;
endpackage

// File: rtl/cycle_sequencer.sv
// cycle_sequencer: registered 4-phase instruction-cycle controller with run/step,
// branch/skip flush and a retired-instruction counter.
module cycle_sequencer
  import core_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             step,
  input  logic             branch_take,
  input  logic             skip_take,
  output logic             q1_fetch,
  output logic             q2_data,
  output logic             q3_alu,
  output logic             q4_save,
  output logic             wb_en,
  output logic             inst_valid,
  output logic             pc_inc,
  output logic             pc_load,
  output logic [1:0]       phase,
  output logic             busy,
  output logic [CNT_W-1:0] retired
);
  phase_t           state_q, state_d;
  logic             step_pend_q, step_pend_d;
  logic             flush_pend_q, flush_pend_d;
  logic             inst_valid_q, inst_valid_d;
  logic             branch_q, branch_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             start, sample;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      step_pend_q  <= 1'b0;
      flush_pend_q <= 1'b0;
      inst_valid_q <= 1'b1;
      branch_q     <= 1'b0;
      retired_q    <= '0;
    end else begin
      state_q      <= state_d;
      step_pend_q  <= step_pend_d;
      flush_pend_q <= flush_pend_d;
      inst_valid_q <= inst_valid_d;
      branch_q     <= branch_d;
      retired_q    <= retired_d;
    end
  end

  // A new cycle may only begin from IDLE or as the back-to-back successor of Q4.
  always_comb begin
    start        = (state_q == IDLE || state_q == Q4) && (run || step_pend_q);
    sample       = state_q == Q3 && inst_valid_q;
    state_d      = start ? Q1 :
                   state_q == Q1 ? Q2 :
                   state_q == Q2 ? Q3 :
                   state_q == Q3 ? Q4 : IDLE;
    step_pend_d  = start ? 1'b0 : step_pend_q | (step & ~run);
    flush_pend_d = start ? 1'b0 : flush_pend_q | (sample & (branch_take | skip_take));
    inst_valid_d = start ? ~flush_pend_q : inst_valid_q;
    branch_d     = state_q == Q3 ? sample & branch_take : branch_q;
    retired_d    = retired_q + {{(CNT_W-1){1'b0}}, state_q == Q4 && inst_valid_q};
  end

  always_comb begin
    q1_fetch   = state_q == Q1;
    q2_data    = state_q == Q2;
    q3_alu     = state_q == Q3;
    q4_save    = state_q == Q4;
    wb_en      = q4_save & inst_valid_q;
    pc_load    = q4_save & branch_q;
    pc_inc     = q4_save & ~branch_q;
    inst_valid = inst_valid_q;
    busy       = state_q != IDLE;
    retired    = retired_q;
    phase      = q2_data ? PHASE_Q2 : q3_alu ? PHASE_Q3 : q4_save ? PHASE_Q4 : PHASE_Q1;
  end
endmodule

// File: tb/tb_cycle_sequencer.sv
// tb_cycle_sequencer: checks the sequencer every cycle against a phase-position model
module tb_cycle_sequencer;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       run = 1'b0, step = 1'b0, branch_take = 1'b0, skip_take = 1'b0;
  logic       q1_fetch, q2_data, q3_alu, q4_save, wb_en, inst_valid, pc_inc, pc_load, busy;
  logic [1:0] phase;
  logic [3:0] retired;
  int n_pass = 0, n_total = 0;
  int m_pos, m_ret;
  bit m_pend, m_flush, m_valid, m_br;

  cycle_sequencer #(.CNT_W(4)) dut (
    .clk(clk), .reset(reset), .run(run), .step(step),
    .branch_take(branch_take), .skip_take(skip_take),
    .q1_fetch(q1_fetch), .q2_data(q2_data), .q3_alu(q3_alu), .q4_save(q4_save),
    .wb_en(wb_en), .inst_valid(inst_valid), .pc_inc(pc_inc), .pc_load(pc_load),
    .phase(phase), .busy(busy), .retired(retired)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input int a, input int e);
    n_total++;
    if (a == e) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", n, a, e, $time);
  endtask

  task automatic model_reset();
    m_pos = -1; m_ret = 0; m_pend = 0; m_flush = 0; m_valid = 1; m_br = 0;
  endtask

  // m_pos: -1 idle, 0..3 = Q1..Q4; advanced once per rising edge from pre-edge inputs
  task automatic model_step();
    bit go;
    if (!reset) begin model_reset(); return; end
    go = (m_pos == -1 || m_pos == 3) && (run || m_pend);
    if (m_pos == 3 && m_valid) m_ret = (m_ret + 1) % 16;
    if (m_pos == 2) begin
      m_br = m_valid && branch_take;
      if (m_valid && (branch_take || skip_take)) m_flush = 1;
    end
    if (go) m_pend = 0;
    else if (step && !run) m_pend = 1;
    if (go) begin m_valid = !m_flush; m_flush = 0; end
    m_pos = go ? 0 : (m_pos == 3 || m_pos == -1) ? -1 : m_pos + 1;
  endtask

  task automatic check_all();
    chk("q1_fetch", q1_fetch, m_pos == 0);
    chk("q2_data", q2_data, m_pos == 1);
    chk("q3_alu", q3_alu, m_pos == 2);
    chk("q4_save", q4_save, m_pos == 3);
    chk("wb_en", wb_en, m_pos == 3 && m_valid);
    chk("pc_load", pc_load, m_pos == 3 && m_br);
    chk("pc_inc", pc_inc, m_pos == 3 && !m_br);
    chk("inst_valid", inst_valid, m_valid);
    chk("phase", phase, m_pos < 0 ? 0 : m_pos);
    chk("busy", busy, m_pos >= 0);
    chk("retired", retired, m_ret);
  endtask

  task automatic cycle(input bit r, input bit s, input bit b, input bit k);
    run = r; step = s; branch_take = b; skip_take = k;
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic cycles(input int n, input bit r);
    for (int i = 0; i < n; i++) cycle(r, 0, 0, 0);
  endtask

  initial begin
    bit r = 1;
    #2 reset = 1'b0;
    model_reset();
    @(negedge clk);
    check_all();
    chk("rst_busy", busy, 0);
    chk("rst_inst_valid", inst_valid, 1);
    chk("rst_retired", retired, 0);
    cycles(2, 0);
    reset = 1'b1;
    // free run
    cycles(13, 1);
    chk("run_retired3", retired, 3);
    chk("run_q1", q1_fetch, 1);
    // branch, then flushed cycle with branch+skip ignored
    cycles(2, 1);
    cycle(1, 0, 1, 0);
    chk("br_pc_load", pc_load, 1);
    chk("br_pc_inc", pc_inc, 0);
    cycle(1, 0, 0, 0);
    chk("flush_valid", inst_valid, 0);
    chk("flush_ret", retired, 4);
    cycles(2, 1);
    cycle(1, 0, 1, 1);
    chk("flush_pc_inc", pc_inc, 1);
    chk("flush_wb_en", wb_en, 0);
    cycle(1, 0, 0, 0);
    chk("after_flush_ret", retired, 4);
    chk("after_flush_valid", inst_valid, 1);
    // branch and skip together
    cycles(2, 1);
    cycle(1, 0, 1, 1);
    chk("both_pc_load", pc_load, 1);
    chk("both_pc_inc", pc_inc, 0);
    chk("both_wb_en", wb_en, 1);
    // async reset mid-Q4
    reset = 1'b0;
    model_reset();
    #1;
    check_all();
    chk("arst_wb_en", wb_en, 0);
    chk("arst_pc_load", pc_load, 0);
    chk("arst_retired", retired, 0);
    cycle(0, 0, 0, 0);
    reset = 1'b1;
    // single step
    cycle(0, 1, 0, 0);
    chk("step_idle", busy, 0);
    cycle(0, 0, 0, 0);
    chk("step_q1", q1_fetch, 1);
    cycles(3, 0);
    chk("step_q4", q4_save, 1);
    cycle(0, 0, 0, 0);
    chk("step_done_busy", busy, 0);
    chk("step_done_ret", retired, 1);
    cycle(0, 1, 0, 0);
    cycle(0, 1, 0, 0);
    cycles(4, 0);
    chk("dstep_busy", busy, 0);
    chk("dstep_ret", retired, 2);
    cycle(0, 0, 0, 0);
    chk("dstep_stays_idle", busy, 0);
    // run drop in Q2 with skip in last cycle
    cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 0);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 1);
    chk("drop_q4", q4_save, 1);
    cycle(0, 0, 0, 0);
    chk("drop_idle", busy, 0);
    chk("drop_ret", retired, 3);
    cycles(2, 0);
    cycle(1, 0, 0, 0);
    chk("resume_q1", q1_fetch, 1);
    chk("resume_flushed", inst_valid, 0);
    // counter wrap
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    cycle(0, 0, 0, 0);
    reset = 1'b1;
    cycles(61, 1);
    chk("wrap_15", retired, 15);
    cycles(4, 1);
    chk("wrap_0", retired, 0);
    cycles(4, 1);
    chk("wrap_1", retired, 1);
    // random traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) == 0) r = !r;
      cycle(r, $urandom_range(0, 7) == 0, $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0);
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
